// File: rtl/object_spawner_if.sv
// Spawn-controller bus: frame/enable/free-slot inputs and the load pulse, lane and status outputs.
// The master drives enable/tick/free; the slave is the spawner.
interface object_spawner_if #(
   parameter int N_OBJ = 10
);
   logic             enable;
   logic             tick;
   logic [N_OBJ-1:0] free;
   logic [N_OBJ-1:0] load_x;
   logic [3:0]       rand_int;
   logic             stalled;
   logic [7:0]       spawn_count;

   modport master (
      output enable, tick, free,
      input  load_x, rand_int, stalled, spawn_count
   );

   modport slave (
      input  enable, tick, free,
      output load_x, rand_int, stalled, spawn_count
   );
endinterface

// File: rtl/object_spawner.sv
// Periodic falling-object spawner: every SPAWN_PERIOD ticks it loads the lowest free slot with an LFSR lane.
// Optional SPAWN_NO_REPEAT_EN: bump the lane by one when it would repeat the previous spawn's lane.
//
// state | meaning
// IDLE  | spawning disabled, counter parked at reload value
// COUNT | down-counting frame ticks toward the next spawn
// PICK  | spawn due: sample free, choose slot and lane (stalls while nothing is free)
// LOAD  | load_x pulse cycle, counter reload, spawn_count bump
module object_spawner #(
   parameter int          N_OBJ        = 10,
   parameter int          SPAWN_PERIOD = 50,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input logic             clk,
   input logic             reset,
   object_spawner_if.slave bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_COUNT = 2'd1;
   localparam logic [1:0] S_PICK  = 2'd2;
   localparam logic [1:0] S_LOAD  = 2'd3;

   localparam logic [7:0] RELOAD = 8'(SPAWN_PERIOD - 1);

   logic [1:0]       state;
   logic [7:0]       tick_cnt;
   logic [15:0]      lfsr;
   logic [N_OBJ-1:0] load_x_q;
   logic [3:0]       rand_int_q;
   logic             stalled_q;
   logic [7:0]       spawn_count_q;
   logic [N_OBJ-1:0] pick_onehot;
   logic [3:0]       lane_next;
   logic             lfsr_fb;

   // Isolating the lowest set bit keeps load_x strictly one-hot with bit 0 winning.
   assign pick_onehot = bus.free & (~bus.free + N_OBJ'(1));

   assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr_fb, lfsr[15:1]};
      end
   end

`ifdef SPAWN_NO_REPEAT_EN
   logic [3:0] last_lane;

   assign lane_next = (lfsr[3:0] == last_lane) ? lfsr[3:0] + 4'd1 : lfsr[3:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         last_lane <= 4'd0;
      end else if (state == S_LOAD) begin
         last_lane <= rand_int_q;
      end
   end
`else
   assign lane_next = lfsr[3:0];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         tick_cnt      <= RELOAD;
         load_x_q      <= '0;
         rand_int_q    <= 4'd0;
         stalled_q     <= 1'b0;
         spawn_count_q <= 8'd0;
      end else begin
         load_x_q <= '0;
         case (state)
            S_IDLE: begin
               if (bus.enable) begin
                  state    <= S_COUNT;
                  tick_cnt <= RELOAD;
               end
            end
            S_COUNT: begin
               if (!bus.enable) begin
                  state <= S_IDLE;
               end else if (bus.tick) begin
                  if (tick_cnt == 8'd0) begin
                     state <= S_PICK;
                  end else begin
                     tick_cnt <= tick_cnt - 8'd1;
                  end
               end
            end
            S_PICK: begin
               if (!bus.enable) begin
                  state     <= S_IDLE;
                  stalled_q <= 1'b0;
               end else if (bus.free != '0) begin
                  state      <= S_LOAD;
                  rand_int_q <= lane_next;
                  load_x_q   <= pick_onehot;
                  stalled_q  <= 1'b0;
               end else begin
                  stalled_q <= 1'b1;
               end
            end
            S_LOAD: begin
               state    <= S_COUNT;
               tick_cnt <= RELOAD;
               if (spawn_count_q != 8'hFF) begin
                  spawn_count_q <= spawn_count_q + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.load_x      = load_x_q;
   assign bus.rand_int    = rand_int_q;
   assign bus.stalled     = stalled_q;
   assign bus.spawn_count = spawn_count_q;

endmodule

// File: tb/tb_object_spawner.sv
// Directed bench for object_spawner with SPAWN_PERIOD=3: slot priority table plus latency, stall, enable, reset and saturation sequences.
// A reference LFSR predicts the lane carried by every load pulse.
module tb_object_spawner;
   localparam int          N_OBJ  = 10;
   localparam int          PERIOD = 3;
   localparam logic [15:0] SEED   = 16'hACE1;

   typedef struct {
      logic [9:0] free;
      logic [9:0] exp_load;
   } vec_t;

   logic clk = 1'b0;
   logic reset;

   object_spawner_if #(.N_OBJ(N_OBJ)) sif ();

   object_spawner #(
      .N_OBJ(N_OBJ),
      .SPAWN_PERIOD(PERIOD),
      .LFSR_SEED(SEED)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(sif)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] m_lfsr;
   logic [15:0] m_prev;
   logic [3:0]  m_lane;
   logic [9:0]  prev_load = '0;
`ifdef SPAWN_NO_REPEAT_EN
   logic [3:0]  m_last = '0;
`endif

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      logic b;
      b = s[0] ^ s[2] ^ s[3] ^ s[5];
      return (s >> 1) | {b, 15'd0};
   endfunction

   always @(posedge clk) begin
      if (reset) m_lfsr <= SEED;
      else       m_lfsr <= lfsr_step(m_lfsr);
      m_prev <= m_lfsr;
   end

   // Every load pulse: lane matches the reference, pulse is one-hot and lasts one cycle.
   always @(negedge clk) begin
      logic [3:0] exp_lane;
      if (sif.load_x != '0) begin
         exp_lane = m_prev[3:0];
`ifdef SPAWN_NO_REPEAT_EN
         if (exp_lane == m_last) exp_lane = exp_lane + 4'd1;
         m_last = exp_lane;
`endif
         m_lane = exp_lane;
         check("lane", 32'(sif.rand_int), 32'(exp_lane));
         check("onehot", 32'($onehot(sif.load_x)), 32'd1);
         check("single_cycle", 32'(prev_load), 32'd0);
      end
`ifdef SPAWN_NO_REPEAT_EN
      if (reset) m_last = '0;
`endif
      prev_load = sif.load_x;
   end

   task automatic wait_load(output logic [9:0] lx, output int cyc, input string nm);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (sif.load_x == '0 && cyc < 200);
      lx = sif.load_x;
      if (lx == '0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: no load_x within %0d cycles", nm, cyc);
      end
   endtask

   task automatic wait_stall(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!sif.stalled && cyc < 50);
   endtask

   initial begin
      vec_t       vt[8];
      logic [9:0] lx;
      int         cyc;
      int         bad;

      vt[0] = '{10'h3F8, 10'h008};
      vt[1] = '{10'h200, 10'h200};
      vt[2] = '{10'h3FF, 10'h001};
      vt[3] = '{10'h0F0, 10'h010};
      vt[4] = '{10'h300, 10'h100};
      vt[5] = '{10'h001, 10'h001};
      vt[6] = '{10'h2AA, 10'h002};
      vt[7] = '{10'h180, 10'h080};

      reset      = 1'b1;
      sif.enable = 1'b0;
      sif.tick   = 1'b0;
      sif.free   = '0;
      repeat (3) @(negedge clk);
      check("rst_load_x", 32'(sif.load_x), 32'd0);
      check("rst_rand_int", 32'(sif.rand_int), 32'd0);
      check("rst_stalled", 32'(sif.stalled), 32'd0);
      check("rst_spawn_count", 32'(sif.spawn_count), 32'd0);

      // IDLE->COUNT, three ticks down to PICK, then LOAD: pulse on the 5th edge.
      reset      = 1'b0;
      sif.enable = 1'b1;
      sif.tick   = 1'b1;
      sif.free   = 10'h3FF;
      wait_load(lx, cyc, "first");
      check("first_latency", 32'(cyc), 32'd5);
      check("first_load", 32'(lx), 32'h001);
      check("count_during_pulse", 32'(sif.spawn_count), 32'd0);
      @(negedge clk);
      check("rand_hold", 32'(sif.rand_int), 32'(m_lane));
      check("load_drop", 32'(sif.load_x), 32'd0);
      check("count_after_pulse", 32'(sif.spawn_count), 32'd1);
      // One cycle already elapsed; spacing is PERIOD+2 = 5.
      wait_load(lx, cyc, "spacing");
      check("spacing", 32'(cyc + 1), 32'd5);

      for (int i = 0; i < 8; i++) begin
         sif.free = vt[i].free;
         wait_load(lx, cyc, "vec");
         check("vec_load", 32'(lx), 32'(vt[i].exp_load));
      end

      // Counter must hold without ticks.
      sif.tick = 1'b0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (sif.load_x != '0) bad++;
      end
      check("tick_hold", 32'(bad), 32'd0);
      sif.tick = 1'b1;
      wait_load(lx, cyc, "tick_resume");
      check("tick_resume_latency", 32'(cyc), 32'd4);

      sif.free = '0;
      wait_stall(cyc);
      check("stall_latency", 32'(cyc), 32'd5);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (sif.load_x != '0 || !sif.stalled) bad++;
      end
      check("stall_hold", 32'(bad), 32'd0);
      sif.free = 10'h010;
      wait_load(lx, cyc, "unstall");
      check("unstall_latency_ok", 32'(cyc <= 2), 32'd1);
      check("unstall_load", 32'(lx), 32'h010);
      check("unstall_stalled", 32'(sif.stalled), 32'd0);

      sif.free = '0;
      wait_stall(cyc);
      check("stall2_latency", 32'(cyc), 32'd5);
      sif.enable = 1'b0;
      @(negedge clk);
      check("disable_stalled", 32'(sif.stalled), 32'd0);
      sif.free = 10'h3FF;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (sif.load_x != '0 || sif.stalled) bad++;
      end
      check("idle_quiet", 32'(bad), 32'd0);
      sif.enable = 1'b1;
      wait_load(lx, cyc, "reenable");
      check("reenable_latency", 32'(cyc), 32'd5);
      check("reenable_load", 32'(lx), 32'h001);

      // Reset landing in the LOAD cycle.
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_load_x", 32'(sif.load_x), 32'd0);
      check("rst_mid_count", 32'(sif.spawn_count), 32'd0);
      reset = 1'b0;
      wait_load(lx, cyc, "post_reset");
      check("post_reset_latency", 32'(cyc), 32'd5);

      for (int i = 0; i < 300; i++) begin
         wait_load(lx, cyc, "sat");
         if (lx == '0) break;
      end
      @(negedge clk);
      check("saturate", 32'(sif.spawn_count), 32'd255);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
